pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Owns the fetch program counter for the single-cycle/pipelined CPU.
- Each cycle it picks the next PC from three sources: sequential, branch/jump redirect, or exception return.
- Each candidate PC is checked against the legal instruction window and for word alignment.
- An illegal candidate forces a trap sequence into a fixed handler address; the faulting context is recorded for later return.

Parameters:
- PC_INIT, 32'h0000_3000, PC value loaded at reset.
- PC_LO, 32'h0000_3000, lowest legal instruction address (inclusive).
- PC_HI, 32'h0000_4fff, highest legal instruction address (inclusive).
- HANDLER, 32'h0000_4180, exception handler entry address.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC this cycle (pipeline stall).
- br_req  in  1  redirect request, valid for one cycle.
- br_target  in  32  redirect address, sampled when br_req=1.
- eret  in  1  return from handler, one-cycle pulse.
- pc  out  32  current fetch PC, registered.
- pc_valid  out  1  pc is fetchable this cycle.
- exc  out  1  one-cycle pulse on trap entry.
- epc  out  32  PC of the instruction whose successor faulted.
- badvaddr  out  32  the rejected candidate address.
- in_handler  out  1  high while the sequencer is in HANDLER state.

Behaviour:
- Reset (async, rst_n=0):
  - pc=PC_INIT, state=RUN, pend_vld=0, pend_tgt=0.
  - epc=0, badvaddr=0, exc=0, in_handler=0.
  - pc_valid=1 from the first cycle after reset release.
- States:
  - RUN: normal execution.
  - TRAP: single flush cycle.
  - HANDLER: executing the handler.
  - LOCK: double fault.
- pc_valid=1 in RUN and HANDLER, 0 in TRAP and LOCK.
- in_handler=1 only in HANDLER.
- Candidate selection (RUN/HANDLER, stall=0), priority high to low:
  - eret in HANDLER: epc+4.
  - br_req: br_target.
  - pend_vld: pend_tgt.
  - otherwise: pc+4.
  - All adds are 32-bit modulo 2^32.
- Check rule: bad = (cand < PC_LO) | (cand > PC_HI) | (cand[1:0] != 0).
- Good candidate:
  - pc <= cand next edge.
  - pend_vld <= 0.
  - eret moves HANDLER to RUN.
- Bad candidate in RUN:
  - pc held, state -> TRAP.
  - epc <= pc, badvaddr <= cand.
  - exc=1 for exactly that next cycle; pend_vld cleared.
- TRAP:
  - Transitions unconditionally to HANDLER (ignores stall, br_req, eret).
  - pc <= HANDLER.
- Bad candidate in HANDLER (including a bad eret return):
  - state -> LOCK, pc held, exc not re-pulsed.
  - epc unchanged; badvaddr <= cand.
  - LOCK exits only via rst_n.
- eret in RUN or TRAP is ignored (no state change).
- stall=1 in RUN/HANDLER:
  - pc, state and epc hold.
  - br_req is latched: pend_vld<=1, pend_tgt<=br_target (last request wins).
  - eret during stall is dropped.
- Pending redirect:
  - Consumed on the first stall=0 cycle.
  - A fresh br_req on that same cycle overrides it.
- Sequential overflow: pc=0x4ffc with no redirect gives cand 0x5000, which traps.
- Reset mid-TRAP or mid-HANDLER returns to the full reset state immediately.

Optional Feature:
- Macro PC_STATS_EN.
- Defined:
  - Adds output port fetch_cnt [31:0], reset to 0.
  - Increments on every cycle where pc updates to a good candidate; wraps at 2^32.
  - Adds output port trap_cnt [15:0], incrementing on each exc pulse and saturating at 16'hffff.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Sequential run: release reset, stall=0 for 4 cycles -> pc = 0x3000, 0x3004, 0x3008, 0x300c; exc=0, pc_valid=1 throughout.
- Misaligned branch:
  - Stimulus: at pc=0x3010, br_req=1, br_target=0x3102.
  - Next cycle: exc=1, epc=0x3010, badvaddr=0x3102, state TRAP, pc_valid=0.
  - Following cycle: pc=0x4180, in_handler=1.
  - Then eret=1 -> pc=0x3014, in_handler=0.
- Stall with redirect:
  - Stimulus: stall=1 for 3 cycles at pc=0x3020; br_req pulses with 0x3400 then 0x3800.
  - During stall: pc holds 0x3020.
  - First unstalled cycle: pc=0x3800.
- Upper-bound overflow:
  - Stimulus: br_target=0x4ffc accepted, then sequential.
  - Response: exc=1, epc=0x4ffc, badvaddr=0x5000.
  - Next cycle: pc=0x4180.
- Double fault:
  - Stimulus: in HANDLER, br_req target 0x2000.
  - Response: state LOCK, pc_valid=0, badvaddr=0x2000, exc stays 0, pc frozen.
  - Async rst_n pulse mid-cycle -> pc=0x3000 immediately, RUN.
- PC_STATS_EN build: run the misaligned-branch scenario -> trap_cnt=1; fetch_cnt equals the number of good pc updates.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-PC sequencer bus: pipeline control inputs and PC/trap status outputs.
// The PC_STATS_EN build adds the fetch_cnt/trap_cnt statistics signals.
interface pc_sequencer_if;
    logic        stall;
    logic        br_req;
    logic [31:0] br_target;
    logic        eret;
    logic [31:0] pc;
    logic        pc_valid;
    logic        exc;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic        in_handler;
`ifdef PC_STATS_EN
    logic [31:0] fetch_cnt;
    logic [15:0] trap_cnt;
`endif

    modport master (
        output stall, br_req, br_target, eret,
`ifdef PC_STATS_EN
        input  fetch_cnt, trap_cnt,
`endif
        input  pc, pc_valid, exc, epc, badvaddr, in_handler
    );

    modport slave (
        input  stall, br_req, br_target, eret,
`ifdef PC_STATS_EN
        output fetch_cnt, trap_cnt,
`endif
        output pc, pc_valid, exc, epc, badvaddr, in_handler
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch program counter with window/alignment checking and trap sequencing.
// Optional macro PC_STATS_EN adds fetch_cnt and trap_cnt statistics counters.
module pc_sequencer #(
    parameter logic [31:0] PC_INIT = 32'h0000_3000,
    parameter logic [31:0] PC_LO   = 32'h0000_3000,
    parameter logic [31:0] PC_HI   = 32'h0000_4fff,
    parameter logic [31:0] HANDLER = 32'h0000_4180
) (
    input logic          clk,
    input logic          rst_n,
    pc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_TRAP    = 2'd1,
        ST_HANDLER = 2'd2,
        ST_LOCK    = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] epc_r;
    logic [31:0] badvaddr_r;
    logic [31:0] pend_tgt_r;
    logic        pend_vld_r;
    logic        exc_r;
    logic        pc_valid_r;
    logic        in_handler_r;
    logic [31:0] cand_s;
    logic        bad_s;
    logic        ret_s;
`ifdef PC_STATS_EN
    logic [31:0] fetch_cnt_r;
    logic [15:0] trap_cnt_r;
`endif

    // Next-PC candidate selection and legality check.
    always_comb begin
        ret_s = (state_r == ST_HANDLER) && bus.eret;
        if (ret_s) begin
            cand_s = epc_r + 32'd4;
        end else if (bus.br_req) begin
            cand_s = bus.br_target;
        end else if (pend_vld_r) begin
            cand_s = pend_tgt_r;
        end else begin
            cand_s = pc_r + 32'd4;
        end
        bad_s = (cand_s < PC_LO) || (cand_s > PC_HI) || (cand_s[1:0] != 2'b00);
    end

    // Sequencer state machine with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_RUN;
            pc_r         <= PC_INIT;
            epc_r        <= 32'd0;
            badvaddr_r   <= 32'd0;
            pend_tgt_r   <= 32'd0;
            pend_vld_r   <= 1'b0;
            exc_r        <= 1'b0;
            pc_valid_r   <= 1'b1;
            in_handler_r <= 1'b0;
`ifdef PC_STATS_EN
            fetch_cnt_r  <= 32'd0;
            trap_cnt_r   <= 16'd0;
`endif
        end else begin
            exc_r <= 1'b0;
            case (state_r)
                ST_RUN, ST_HANDLER: begin
                    if (bus.stall) begin
                        // Eret is dropped while stalled; only redirects survive.
                        if (bus.br_req) begin
                            pend_vld_r <= 1'b1;
                            pend_tgt_r <= bus.br_target;
                        end
                    end else if (!bad_s) begin
                        pc_r       <= cand_s;
                        pend_vld_r <= 1'b0;
`ifdef PC_STATS_EN
                        fetch_cnt_r <= fetch_cnt_r + 32'd1;
`endif
                        if (ret_s) begin
                            state_r      <= ST_RUN;
                            in_handler_r <= 1'b0;
                        end
                    end else if (state_r == ST_RUN) begin
                        state_r    <= ST_TRAP;
                        pc_valid_r <= 1'b0;
                        epc_r      <= pc_r;
                        badvaddr_r <= cand_s;
                        exc_r      <= 1'b1;
                        pend_vld_r <= 1'b0;
`ifdef PC_STATS_EN
                        if (trap_cnt_r != 16'hffff) begin
                            trap_cnt_r <= trap_cnt_r + 16'd1;
                        end
`endif
                    end else begin
                        // Fault inside the handler: epc must keep the original context.
                        state_r      <= ST_LOCK;
                        pc_valid_r   <= 1'b0;
                        in_handler_r <= 1'b0;
                        badvaddr_r   <= cand_s;
                        pend_vld_r   <= 1'b0;
                    end
                end
                ST_TRAP: begin
                    state_r      <= ST_HANDLER;
                    pc_r         <= HANDLER;
                    pc_valid_r   <= 1'b1;
                    in_handler_r <= 1'b1;
                end
                ST_LOCK: begin
                    pc_valid_r   <= 1'b0;
                    in_handler_r <= 1'b0;
                end
                default: begin
                    state_r      <= ST_LOCK;
                    pc_valid_r   <= 1'b0;
                    in_handler_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc         = pc_r;
    assign bus.pc_valid   = pc_valid_r;
    assign bus.exc        = exc_r;
    assign bus.epc        = epc_r;
    assign bus.badvaddr   = badvaddr_r;
    assign bus.in_handler = in_handler_r;
`ifdef PC_STATS_EN
    assign bus.fetch_cnt  = fetch_cnt_r;
    assign bus.trap_cnt   = trap_cnt_r;
`endif
endmodule
